// File: rtl/p10_pkg_common.sv
// Shared types and the parameter ROM table for the p10 parameter controller.
package p10_pkg_common;

    localparam int unsigned PRM_VAL_W = 32;

    // Parameter addresses
    localparam int unsigned ADDR_FREQ_HZ      = 0;
    localparam int unsigned ADDR_DUTY_PERCENT = 1;
    localparam int unsigned ADDR_PHASE_DEG    = 2;
    localparam int unsigned ADDR_AMPL_MV      = 3;
    localparam int unsigned ADDR_DEADTIME_NS  = 4;
    localparam int unsigned ADDR_HW_REV       = 5;
    localparam int unsigned ADDR_CMD_START    = 6;
    localparam int unsigned ADDR_CMD_MODE     = 7;

    typedef enum logic [1:0] {
        PRM_RO = 2'd0,
        PRM_WO = 2'd1,
        PRM_RW = 2'd2
    } prm_rights_t;

    typedef enum logic [1:0] {
        RSP_OK        = 2'd0,
        RSP_BAD_ADDR  = 2'd1,
        RSP_NO_RIGHTS = 2'd2,
        RSP_RANGE     = 2'd3
    } rsp_status_t;

    typedef struct packed {
        prm_rights_t          rights;
        logic                 is_exec;
        logic [PRM_VAL_W-1:0] min;
        logic [PRM_VAL_W-1:0] max;
    } prm_entry_t;

    // Descriptor table; unknown addresses return an all-zero read-only entry.
    function automatic prm_entry_t prm_rom_lookup(input logic [31:0] idx);
        prm_entry_t e;
        e = '{rights: PRM_RO, is_exec: 1'b0, min: '0, max: '0};
        case (idx)
            ADDR_FREQ_HZ:      e = '{rights: PRM_RW, is_exec: 1'b0, min: 32'd0,   max: 32'd1_000_000};
            ADDR_DUTY_PERCENT: e = '{rights: PRM_RW, is_exec: 1'b0, min: 32'd0,   max: 32'd50};
            ADDR_PHASE_DEG:    e = '{rights: PRM_RW, is_exec: 1'b0, min: 32'd0,   max: 32'd359};
            ADDR_AMPL_MV:      e = '{rights: PRM_RW, is_exec: 1'b0, min: 32'd100, max: 32'd5000};
            ADDR_DEADTIME_NS:  e = '{rights: PRM_RW, is_exec: 1'b0, min: 32'd10,  max: 32'd1000};
            ADDR_HW_REV:       e = '{rights: PRM_RO, is_exec: 1'b0, min: 32'd3,   max: 32'd3};
            ADDR_CMD_START:    e = '{rights: PRM_WO, is_exec: 1'b1, min: 32'd0,   max: 32'd1};
            ADDR_CMD_MODE:     e = '{rights: PRM_RW, is_exec: 1'b1, min: 32'd0,   max: 32'd3};
            default:           e = '{rights: PRM_RO, is_exec: 1'b0, min: '0,      max: '0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/p10_rom.sv
// Synchronous parameter descriptor ROM: entry is valid one cycle after i_addr.
module p10_rom
    import p10_pkg_common::*;
#(
    parameter int unsigned AW = 4
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    output prm_entry_t    o_entry
);

    prm_entry_t r_entry;

    // Registered table lookup
    always_ff @(posedge i_clk) begin
        r_entry <= prm_rom_lookup(32'(i_addr));
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/p10_prm_ctrl.sv
// Parameter controller: init sweep, two-requester round-robin arbiter,
// descriptor-checked read/write of the live parameter registers.
module p10_prm_ctrl
    import p10_pkg_common::*;
#(
    parameter int unsigned PRM_COUNT = 8,
    parameter int unsigned VAL_W     = 32,
    parameter int unsigned AW        = $clog2(PRM_COUNT + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      req_v,
    input  logic [1:0]                      req_wr,
    input  logic [1:0][AW-1:0]              req_addr,
    input  logic [1:0][VAL_W-1:0]           req_wdata,
    output logic [1:0]                      req_ready,
    output logic                            rsp_v,
    output logic                            rsp_id,
    output logic [1:0]                      rsp_status,
    output logic [VAL_W-1:0]                rsp_rdata,
    output logic [PRM_COUNT-1:0][VAL_W-1:0] prm_val,
    output logic                            exec_v,
    output logic [AW-1:0]                   exec_addr,
    output logic                            init_done
);

    localparam int unsigned IDX_W = (PRM_COUNT > 1) ? $clog2(PRM_COUNT) : 1;

    localparam logic [1:0] S_INIT  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;
    localparam logic [1:0] S_CHECK = 2'd3;

    logic [1:0]                      r_state;
    logic [1:0]                      w_state_nxt;
    logic [AW-1:0]                   r_sweep_addr;
    logic                            r_last;
    logic                            r_id;
    logic                            r_wr;
    logic [AW-1:0]                   r_addr;
    logic [VAL_W-1:0]                r_wdata;
    logic [PRM_COUNT-1:0][VAL_W-1:0] r_prm_val;

    logic [1:0]       w_grant;
    logic             w_hs;
    logic             w_gnt_id;
    logic [AW-1:0]    w_rom_addr;
    prm_entry_t       w_entry;
    rsp_status_t      w_status;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_sweep_idx;
    logic             w_sweep_last;

    assign w_idx        = IDX_W'(r_addr);
    assign w_sweep_idx  = IDX_W'(r_sweep_addr - AW'(1));
    assign w_sweep_last = (r_sweep_addr == AW'(PRM_COUNT));
    assign w_rom_addr   = (r_state == S_INIT) ? r_sweep_addr : r_addr;

    p10_rom #(
        .AW (AW)
    ) u_rom (
        .i_clk   (clk),
        .i_addr  (w_rom_addr),
        .o_entry (w_entry)
    );

    // Round-robin arbiter: on contention the requester not granted last wins
    always_comb begin
        w_grant = 2'b00;
        if (r_state == S_IDLE) begin
            if (req_v == 2'b11) begin
                w_grant = r_last ? 2'b01 : 2'b10;
            end else begin
                w_grant = req_v;
            end
        end
    end

    assign req_ready = w_grant;
    assign w_hs      = |w_grant;
    assign w_gnt_id  = w_grant[1];

    // Descriptor check of the latched request, in priority order
    always_comb begin
        w_status = RSP_OK;
        if (r_addr >= AW'(PRM_COUNT)) begin
            w_status = RSP_BAD_ADDR;
        end else if ((!r_wr && w_entry.rights == PRM_WO) ||
                     ( r_wr && w_entry.rights == PRM_RO)) begin
            w_status = RSP_NO_RIGHTS;
        end else if (r_wr && ((r_wdata < VAL_W'(w_entry.min)) ||
                              (r_wdata > VAL_W'(w_entry.max)))) begin
            w_status = RSP_RANGE;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (w_sweep_last) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_hs) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep, request latch, commit and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sweep_addr <= '0;
            init_done    <= 1'b0;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_prm_val    <= '0;
            rsp_v        <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_status   <= 2'd0;
            rsp_rdata    <= '0;
            exec_v       <= 1'b0;
            exec_addr    <= '0;
        end else begin
            rsp_v  <= 1'b0;
            exec_v <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_sweep_addr != '0) begin
                        r_prm_val[w_sweep_idx] <= VAL_W'(w_entry.min);
                    end
                    if (w_sweep_last) begin
                        init_done <= 1'b1;
                    end else begin
                        r_sweep_addr <= r_sweep_addr + AW'(1);
                    end
                end
                S_IDLE: begin
                    if (w_hs) begin
                        r_id    <= w_gnt_id;
                        r_wr    <= req_wr[w_gnt_id];
                        r_addr  <= req_addr[w_gnt_id];
                        r_wdata <= req_wdata[w_gnt_id];
                        r_last  <= w_gnt_id;
                    end
                end
                S_CHECK: begin
                    rsp_v      <= 1'b1;
                    rsp_id     <= r_id;
                    rsp_status <= w_status;
                    rsp_rdata  <= '0;
                    if (w_status == RSP_OK) begin
                        if (r_wr) begin
                            r_prm_val[w_idx] <= r_wdata;
                            if (w_entry.is_exec) begin
                                exec_v    <= 1'b1;
                                exec_addr <= r_addr;
                            end
                        end else begin
                            rsp_rdata <= r_prm_val[w_idx];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign prm_val = r_prm_val;

endmodule

// File: tb/tb_p10_prm_ctrl.sv
// Self-checking bench for p10_prm_ctrl with a transaction-level reference model.
module tb_p10_prm_ctrl;

    localparam int unsigned PRM_COUNT = 8;
    localparam int unsigned VAL_W     = 32;
    localparam int unsigned AW        = $clog2(PRM_COUNT + 1);

    // Model rights codes
    localparam int RT_RO = 0;
    localparam int RT_WO = 1;
    localparam int RT_RW = 2;

    logic                            clk = 1'b0;
    logic                            rst;
    logic [1:0]                      req_v;
    logic [1:0]                      req_wr;
    logic [1:0][AW-1:0]              req_addr;
    logic [1:0][VAL_W-1:0]           req_wdata;
    logic [1:0]                      req_ready;
    logic                            rsp_v;
    logic                            rsp_id;
    logic [1:0]                      rsp_status;
    logic [VAL_W-1:0]                rsp_rdata;
    logic [PRM_COUNT-1:0][VAL_W-1:0] prm_val;
    logic                            exec_v;
    logic [AW-1:0]                   exec_addr;
    logic                            init_done;

    always #5 clk = ~clk;

    p10_prm_ctrl #(
        .PRM_COUNT (PRM_COUNT),
        .VAL_W     (VAL_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_v      (req_v),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_v      (rsp_v),
        .rsp_id     (rsp_id),
        .rsp_status (rsp_status),
        .rsp_rdata  (rsp_rdata),
        .prm_val    (prm_val),
        .exec_v     (exec_v),
        .exec_addr  (exec_addr),
        .init_done  (init_done)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference descriptor table: freq, duty, phase, ampl, deadtime, hw_rev, cmd_start, cmd_mode
    logic [31:0] t_min  [8] = '{32'd0, 32'd0, 32'd0, 32'd100, 32'd10, 32'd3, 32'd0, 32'd0};
    logic [31:0] t_max  [8] = '{32'd1_000_000, 32'd50, 32'd359, 32'd5000, 32'd1000, 32'd3, 32'd1, 32'd3};
    int          t_rts  [8] = '{RT_RW, RT_RW, RT_RW, RT_RW, RT_RW, RT_RO, RT_WO, RT_RW};
    logic        t_exec [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic [31:0] m_val [8];
    int          m_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_val[i] = t_min[i];
        m_last = 1;
    endtask

    // Expected outcome of one request against the current model state
    task automatic model_eval(input logic wr, input int unsigned a, input logic [31:0] wd,
                              output logic [1:0] st, output logic [31:0] rd, output logic ex);
        st = 2'd0;
        rd = '0;
        ex = 1'b0;
        if (a >= PRM_COUNT) begin
            st = 2'd1;
        end else if ((wr && t_rts[3'(a)] == RT_RO) || (!wr && t_rts[3'(a)] == RT_WO)) begin
            st = 2'd2;
        end else if (wr && (wd < t_min[3'(a)] || wd > t_max[3'(a)])) begin
            st = 2'd3;
        end else if (wr) begin
            ex = t_exec[3'(a)];
        end else begin
            rd = m_val[3'(a)];
        end
    endtask

    // Hold both requests through the sweep; ready must stay low until init_done
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        req_v = 2'b11;
        while (init_done !== 1'b1 && n < 50) begin
            #1;
            check_eq({tag, "_ready_in_init"}, 64'(req_ready), 64'(0));
            @(negedge clk);
            n++;
        end
        req_v = 2'b00;
        check_eq({tag, "_init_cycles"}, 64'(n), 64'(PRM_COUNT + 1));
        for (int i = 0; i < 8; i++) begin
            check_eq({tag, "_init_val"}, 64'(prm_val[3'(i)]), 64'(m_val[i]));
        end
    endtask

    task automatic do_req(input int id, input logic wr, input int unsigned a, input logic [31:0] wd);
        logic [1:0]  est;
        logic [31:0] erd;
        logic        eex;
        int          n;
        model_eval(wr, a, wd, est, erd, eex);
        @(negedge clk);
        req_v[id]     = 1'b1;
        req_wr[id]    = wr;
        req_addr[id]  = AW'(a);
        req_wdata[id] = wd;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("grant", 64'(req_ready), 64'((id == 0) ? 2'b01 : 2'b10));
        m_last = id;
        @(negedge clk);
        req_v[id] = 1'b0;
        check_eq("rsp_t1", 64'({rsp_v, exec_v}), 64'(0));
        @(negedge clk);
        check_eq("rsp_t2", 64'({rsp_v, exec_v}), 64'(0));
        @(negedge clk);
        check_eq("rsp_v", 64'(rsp_v), 64'(1));
        check_eq("rsp_id", 64'(rsp_id), 64'(id));
        check_eq("rsp_status", 64'(rsp_status), 64'(est));
        check_eq("rsp_rdata", 64'(rsp_rdata), 64'(erd));
        check_eq("exec_v", 64'(exec_v), 64'(eex));
        if (eex) check_eq("exec_addr", 64'(exec_addr), 64'(a));
        if (est == 2'd0 && wr) m_val[3'(a)] = wd;
        if (a < PRM_COUNT) check_eq("prm_val", 64'(prm_val[3'(a)]), 64'(m_val[3'(a)]));
    endtask

    // Both requesters hold valid reads; grants must alternate every 3 cycles
    task automatic alt_test();
        int exp_id;
        int n;
        int t_prev;
        exp_id = (m_last == 0) ? 1 : 0;
        t_prev = 0;
        @(negedge clk);
        req_wr      = 2'b00;
        req_addr[0] = AW'(0);
        req_addr[1] = AW'(2);
        req_v       = 2'b11;
        for (int g = 0; g < 6; g++) begin
            #1;
            n = 0;
            while (req_ready === 2'b00 && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            check_eq("alt_grant", 64'(req_ready), 64'((exp_id == 0) ? 2'b01 : 2'b10));
            if (g > 0) check_eq("alt_spacing", 64'(cyc - t_prev), 64'(3));
            t_prev = cyc;
            repeat (3) @(negedge clk);
            check_eq("alt_rsp_v", 64'(rsp_v), 64'(1));
            check_eq("alt_rsp_id", 64'(rsp_id), 64'(exp_id));
            check_eq("alt_rdata", 64'(rsp_rdata), 64'(m_val[(exp_id == 0) ? 0 : 2]));
            m_last = exp_id;
            exp_id = 1 - exp_id;
            if (g == 5) req_v = 2'b00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a;
        int          id;
        logic        wr;
        logic [31:0] wd;
        int          n;

        rst       = 1'b1;
        req_v     = 2'b00;
        req_wr    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        req_v = 2'b11;
        #1;
        check_eq("rst_init_done", 64'(init_done), 64'(0));
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        check_eq("rst_rsp", 64'({rsp_v, exec_v, rsp_id, rsp_status}), 64'(0));
        check_eq("rst_rdata", 64'(rsp_rdata), 64'(0));
        check_eq("rst_exec_addr", 64'(exec_addr), 64'(0));
        for (int i = 0; i < 8; i++) check_eq("rst_prm_val", 64'(prm_val[3'(i)]), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_init("por");

        // Directed cases
        do_req(0, 1'b1, 0, 32'd100000);
        do_req(1, 1'b0, 0, 32'd0);
        do_req(0, 1'b1, 1, 32'd51);
        do_req(0, 1'b0, 1, 32'd0);
        do_req(1, 1'b1, 2, 32'd360);
        do_req(1, 1'b1, 2, 32'd359);
        do_req(0, 1'b0, 8, 32'd0);
        do_req(0, 1'b1, 8, 32'd5);
        do_req(1, 1'b1, 15, 32'd1);
        do_req(0, 1'b1, 5, 32'd3);
        do_req(0, 1'b0, 5, 32'd0);
        do_req(1, 1'b0, 6, 32'd0);
        do_req(0, 1'b1, 6, 32'd1);
        @(negedge clk);
        check_eq("exec_single", 64'(exec_v), 64'(0));
        do_req(1, 1'b1, 3, 32'd99);
        do_req(1, 1'b1, 3, 32'd5000);
        do_req(0, 1'b1, 7, 32'd2);

        alt_test();

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            id = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 9);
            case ($urandom_range(0, 3))
                0: wd = (a < 8) ? t_min[3'(a)] + ($urandom % (t_max[3'(a)] - t_min[3'(a)] + 32'd1)) : $urandom;
                1: wd = (a < 8) ? t_max[3'(a)] + 32'd1 : $urandom;
                2: wd = (a < 8 && t_min[3'(a)] != 0) ? t_min[3'(a)] - 32'd1 : $urandom_range(0, 60);
                default: wd = $urandom;
            endcase
            do_req(id, wr, a, wd);
        end

        // Reset in the CHECK cycle of a legal write: nothing commits, sweep restarts
        @(negedge clk);
        req_v[0]     = 1'b1;
        req_wr[0]    = 1'b1;
        req_addr[0]  = AW'(3);
        req_wdata[0] = 32'd4000;
        #1;
        n = 0;
        while (req_ready[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("rstchk_grant", 64'(req_ready), 64'(2'b01));
        @(negedge clk);
        req_v = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstchk_rsp_v", 64'(rsp_v), 64'(0));
        check_eq("rstchk_init_done", 64'(init_done), 64'(0));
        check_eq("rstchk_ampl", 64'(prm_val[3]), 64'(0));
        rst = 1'b0;
        model_reset();
        wait_init("rstchk");
        do_req(1, 1'b0, 3, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
